// File: rtl/uart_tx_arbiter_if.sv
// Purpose: byte-stream bundle between NUM_REQ requesters, the arbiter and one UART TX serialiser.
// Latency: wiring only; timing is owned by uart_tx_arbiter.
// Backpressure: req_ready per requester; tx_busy and active-low cts_n throttle launches.
// Ports: req_valid/req_data/req_last/req_ready (requester side),
//        tx_data/tx_start/tx_busy/cts_n (serialiser side), grant_id/grant_active/burst_trunc (status).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 cts_n;
  logic [GW-1:0]        grant_id;
  logic                 grant_active;
  logic                 burst_trunc;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, tx_busy, cts_n,
    output req_ready, tx_data, tx_start, grant_id, grant_active, burst_trunc
  );

  // Requester / serialiser / observer side.
  modport master (
    output req_valid, req_data, req_last, tx_busy, cts_n,
    input  req_ready, tx_data, tx_start, grant_id, grant_active, burst_trunc
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART transmitter among NUM_REQ byte streams, grant held per packet.
// Latency: grant 1 cycle after request in IDLE; tx_start/tx_data 1 cycle after the transfer edge.
// Backpressure: req_ready only for the grantee in LAUNCH with cts_n low; no launch while tx_busy or cts_n high.
// Ports: clk, reset (async, active-high), bus (uart_tx_arbiter_if.slave): requester handshake,
//        serialiser launch/busy, host cts_n, and grant status outputs.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int         GW    = $clog2(NUM_REQ);
  localparam logic [7:0] MB8   = 8'(MAX_BURST);
  localparam logic [15:0] GAP16 = 16'(GAP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic [7:0]    burst_cnt;
  logic [15:0]   gap_cnt;
  logic          last_q;
  logic          xfer_ok;
  logic          do_grant, do_xfer, do_release, do_trunc, gap_inc;

  // Round-robin pick: first valid index at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin : rr_pick
    logic          found;
    logic [GW-1:0] idx;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign xfer_ok = bus.req_valid[bus.grant_id] & ~bus.cts_n;

  // Only the grantee may see ready, and only while a launch is possible.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == LAUNCH) begin
      bus.req_ready[bus.grant_id] = xfer_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_xfer    = 1'b0;
    do_release = 1'b0;
    do_trunc   = 1'b0;
    gap_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        // tx_busy gate also covers a frame still shifting out after a reset.
        if ((|bus.req_valid) && !bus.tx_busy && !bus.cts_n) begin
          do_grant = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (xfer_ok) begin
          do_xfer = 1'b1;
          state_d = WAIT_ACK;
        end else if (!bus.req_valid[bus.grant_id] && !bus.cts_n) begin
          // Host throttling (cts_n high) does not count against the requester.
          gap_inc = 1'b1;
          if (gap_cnt >= GAP16 - 16'd1) begin
            do_release = 1'b1;
            do_trunc   = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            do_release = 1'b1;
            state_d    = IDLE;
          end else if (burst_cnt == MB8) begin
            do_release = 1'b1;
            do_trunc   = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.grant_id     <= '0;
      bus.grant_active <= 1'b0;
      bus.tx_data      <= 8'h00;
      bus.tx_start     <= 1'b0;
      bus.burst_trunc  <= 1'b0;
      rr_ptr           <= '0;
      burst_cnt        <= 8'd0;
      gap_cnt          <= 16'd0;
      last_q           <= 1'b0;
    end else begin
      bus.tx_start    <= do_xfer;
      bus.burst_trunc <= do_trunc;
      if (do_grant) begin
        bus.grant_id     <= winner;
        bus.grant_active <= 1'b1;
        burst_cnt        <= 8'd0;
        gap_cnt          <= 16'd0;
      end
      if (do_xfer) begin
        bus.tx_data <= bus.req_data[{bus.grant_id, 3'b000} +: 8];
        last_q      <= bus.req_last[bus.grant_id];
        gap_cnt     <= 16'd0;
        if (burst_cnt != 8'hFF) begin
          burst_cnt <= burst_cnt + 8'd1;
        end
      end else if (gap_inc && gap_cnt != GAP16) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
      if (do_release) begin
        bus.grant_active <= 1'b0;
        rr_ptr <= (bus.grant_id == GW'(NUM_REQ - 1)) ? '0 : bus.grant_id + GW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed bench for uart_tx_arbiter with requester queues and a 10-cycle serialiser model.
// Latency: n/a.
// Backpressure: bench drives cts_n and models tx_busy.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .GAP_TIMEOUT(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serialiser model: busy for 10 cycles starting the cycle after tx_start; ignores reset.
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  logic cts_drv = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0) || force_busy;
  assign bus.cts_n   = cts_drv;

  // Requester byte tables; ovr_en forces raw req_valid patterns for the arbitration vectors.
  logic [7:0]    mem [NR][16];
  logic          lst [NR][16];
  int            len [NR];
  int            idx [NR];
  logic          rq_rst = 1'b1;
  logic          ovr_en = 1'b0;
  logic [NR-1:0] ovr_valid = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rq_rst) idx[i] <= 0;
      else if (!ovr_en && bus.req_valid[i] && bus.req_ready[i]) idx[i] <= idx[i] + 1;
    end
  end

  always_comb begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      if (ovr_en) begin
        bus.req_valid[i]       = ovr_valid[i];
        bus.req_data[i*8 +: 8] = 8'hA0;
        bus.req_last[i]        = 1'b1;
      end else if (idx[i] < len[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*8 +: 8] = mem[i][idx[i][3:0]];
        bus.req_last[i]        = lst[i][idx[i][3:0]];
      end
    end
  end

  // Monitor: log launches, truncation pulses and the latest grant release.
  int         n_start, n_trunc, fall_cyc;
  int         st_cyc [32];
  logic [7:0] st_dat [32];
  int         st_id  [32];
  logic       prev_act;
  always @(negedge clk) begin
    if (reset) begin
      n_start  = 0;
      n_trunc  = 0;
      fall_cyc = -1;
      prev_act = 1'b0;
    end else begin
      if (bus.tx_start && n_start < 32) begin
        st_cyc[n_start] = cyc;
        st_dat[n_start] = bus.tx_data;
        st_id[n_start]  = int'(bus.grant_id);
        n_start++;
      end
      if (bus.burst_trunc) n_trunc++;
      if (prev_act && !bus.grant_active) fall_cyc = cyc;
      prev_act = bus.grant_active;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string nm);
    int b = 0;
    while (n_start < n && b < budget) begin
      tick();
      b++;
    end
    chk(nm, 32'(n_start >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int b = 0;
    while ((bus.grant_active || bus.tx_busy) && b < budget) begin
      tick();
      b++;
    end
    chk(nm, 32'(!bus.grant_active && !bus.tx_busy), 32'd1);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NR; i++) len[i] = 0;
    cts_drv = 1'b0;
  endtask

  task automatic do_reset();
    int b = 0;
    while (bus.tx_busy && b < 100) begin
      tick();
      b++;
    end
    reset  = 1'b1;
    rq_rst = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    rq_rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       cts;
    logic       busy;
    logic       act;
    int         id;
    logic [3:0] rdy;
  } vec_t;
  vec_t vt [8];

  initial begin
    int         s, rel;
    int         exp_id [11];
    logic [7:0] exp_dat [11];

    // IDLE arbitration from a fresh reset (rr_ptr = 0), checked one cycle after the request.
    vt[0] = '{4'b0001, 1'b0, 1'b0, 1'b1, 0, 4'b0001};
    vt[1] = '{4'b1100, 1'b0, 1'b0, 1'b1, 2, 4'b0100};
    vt[2] = '{4'b1000, 1'b0, 1'b0, 1'b1, 3, 4'b1000};
    vt[3] = '{4'b1010, 1'b0, 1'b0, 1'b1, 1, 4'b0010};
    vt[4] = '{4'b0110, 1'b1, 1'b0, 1'b0, 0, 4'b0000};
    vt[5] = '{4'b0010, 1'b0, 1'b1, 1'b0, 0, 4'b0000};
    vt[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000};
    vt[7] = '{4'b1111, 1'b0, 1'b0, 1'b1, 0, 4'b0001};

    clear_tables();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_grant_active", 32'(bus.grant_active), 32'd0);
    chk("rst_burst_trunc", 32'(bus.burst_trunc), 32'd0);
    reset  = 1'b0;
    rq_rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      ovr_en     = 1'b1;
      ovr_valid  = vt[v].valid;
      cts_drv    = vt[v].cts;
      force_busy = vt[v].busy;
      tick();
      chk($sformatf("vec%0d_active", v), 32'(bus.grant_active), 32'(vt[v].act));
      chk($sformatf("vec%0d_id", v), 32'(bus.grant_id), 32'(vt[v].id));
      chk($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(vt[v].rdy));
      chk($sformatf("vec%0d_tx_start", v), 32'(bus.tx_start), 32'd0);
      reset      = 1'b1;
      ovr_en     = 1'b0;
      force_busy = 1'b0;
      cts_drv    = 1'b0;
      tick();
      reset = 1'b0;
    end

    // Single packet from requester 2.
    clear_tables();
    mem[2][0] = 8'h41; lst[2][0] = 1'b0;
    mem[2][1] = 8'h42; lst[2][1] = 1'b0;
    mem[2][2] = 8'h43; lst[2][2] = 1'b1;
    len[2] = 3;
    do_reset();
    wait_starts(3, 100, "sp_starts");
    wait_idle(50, "sp_idle");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sp_dat%0d", k), 32'(st_dat[k]), 32'(8'h41 + k));
      chk($sformatf("sp_id%0d", k), 32'(st_id[k]), 32'd2);
    end
    chk("sp_space1", 32'(st_cyc[1] - st_cyc[0]), 32'd13);
    chk("sp_space2", 32'(st_cyc[2] - st_cyc[1]), 32'd13);
    chk("sp_release", 32'(fall_cyc - st_cyc[2]), 32'd12);
    chk("sp_trunc", 32'(n_trunc), 32'd0);

    // Fairness: two 1-byte packets per requester, all pending from reset.
    clear_tables();
    for (int i = 0; i < NR; i++) begin
      mem[i][0] = 8'(i * 16 + 1); lst[i][0] = 1'b1;
      mem[i][1] = 8'(i * 16 + 2); lst[i][1] = 1'b1;
      len[i] = 2;
    end
    do_reset();
    wait_starts(8, 200, "fair_starts");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair_id%0d", k), 32'(st_id[k]), 32'(k % 4));
      chk($sformatf("fair_dat%0d", k), 32'(st_dat[k]), 32'((k % 4) * 16 + 1 + k / 4));
      if (k > 0) chk($sformatf("fair_space%0d", k), 32'(st_cyc[k] - st_cyc[k-1]), 32'd14);
    end
    wait_idle(50, "fair_idle");

    // Burst cap (MAX_BURST = 4): requester 0 streams 10 unterminated bytes, requester 1 waits.
    clear_tables();
    for (int k = 0; k < 10; k++) begin
      mem[0][k] = 8'(k);
      lst[0][k] = 1'b0;
    end
    len[0] = 10;
    mem[1][0] = 8'h80; lst[1][0] = 1'b1; len[1] = 1;
    exp_id  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    exp_dat = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    do_reset();
    wait_starts(11, 400, "bc_starts");
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("bc_id%0d", k), 32'(st_id[k]), 32'(exp_id[k]));
      chk($sformatf("bc_dat%0d", k), 32'(st_dat[k]), 32'(exp_dat[k]));
    end
    wait_idle(100, "bc_idle");
    chk("bc_trunc", 32'(n_trunc), 32'd3);

    // Flow control: cts_n high for 200 cycles after byte 2 of 4.
    clear_tables();
    for (int k = 0; k < 4; k++) begin
      mem[1][k] = 8'(8'h11 + k);
      lst[1][k] = (k == 3);
    end
    len[1] = 4;
    do_reset();
    wait_starts(2, 100, "fc_first2");
    cts_drv = 1'b1;
    for (int k = 0; k < 200; k++) tick();
    chk("fc_held_starts", 32'(n_start), 32'd2);
    chk("fc_held_trunc", 32'(n_trunc), 32'd0);
    chk("fc_held_grant", 32'(bus.grant_active), 32'd1);
    chk("fc_frame_done", 32'(bus.tx_busy), 32'd0);
    rel = cyc;
    cts_drv = 1'b0;
    wait_starts(4, 100, "fc_starts");
    chk("fc_resume", 32'(st_cyc[2] - rel), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fc_dat%0d", k), 32'(st_dat[k]), 32'(8'h11 + k));
    end
    wait_idle(50, "fc_idle");
    chk("fc_trunc", 32'(n_trunc), 32'd0);

    // Gap timeout (GAP_TIMEOUT = 20) on requester 3, then rr_ptr must have wrapped to 0.
    clear_tables();
    mem[3][0] = 8'h33; lst[3][0] = 1'b0; len[3] = 1;
    do_reset();
    wait_starts(1, 50, "gap_start");
    wait_idle(100, "gap_idle");
    chk("gap_release", 32'(fall_cyc - st_cyc[0]), 32'd32);
    chk("gap_trunc", 32'(n_trunc), 32'd1);
    chk("gap_grant_id_kept", 32'(bus.grant_id), 32'd3);
    mem[3][1] = 8'h3B; lst[3][1] = 1'b1; len[3] = 2;
    mem[1][0] = 8'h15; lst[1][0] = 1'b1; len[1] = 1;
    wait_starts(3, 100, "gap_rr_starts");
    chk("gap_rr_first", 32'(st_id[1]), 32'd1);
    chk("gap_rr_second", 32'(st_id[2]), 32'd3);
    wait_idle(50, "gap_rr_idle");

    // Reset three cycles after a launch while the frame is still shifting.
    clear_tables();
    mem[2][0] = 8'h01; lst[2][0] = 1'b0;
    mem[2][1] = 8'h02; lst[2][1] = 1'b1;
    len[2] = 2;
    do_reset();
    wait_starts(1, 50, "rm_start");
    s = st_cyc[0];
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rm_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rm_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rm_grant_active", 32'(bus.grant_active), 32'd0);
    chk("rm_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rm_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rm_burst_trunc", 32'(bus.burst_trunc), 32'd0);
    tick();
    reset = 1'b0;
    wait_starts(1, 100, "rm_restart");
    chk("rm_restart_cycle", 32'(st_cyc[0] - s), 32'd13);
    chk("rm_restart_dat", 32'(st_dat[0]), 32'h02);
    wait_idle(50, "rm_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
